// File: rtl/spi_ram_master.sv
// rtl/spi_ram_master.sv - SPI mode-0 master running single-byte READ (0x03) / WRITE (0x02) on an 8-bit-address SPI RAM
// Optional SPI_WREN_EN: each WRITE is preceded by a separate one-byte WREN (0x06) frame.
module spi_ram_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso,
  output logic       sck
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [3:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] sr_q, sr_d;
  logic [7:0]  rx_q, rx_d, rdata_q, rdata_d;
  logic        we_q, we_d, sck_q, sck_d, cs_n_q, cs_n_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        div_end;
  logic [4:0]  bit_last;

`ifdef SPI_WREN_EN
  logic        wren_q, wren_d;
  logic [15:0] wr_q, wr_d;  // addr/wdata parked while the WREN frame runs
  assign bit_last = wren_q ? 5'd7 : 5'd23;
`else
  assign bit_last = 5'd23;
`endif

  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 4'd1;
    bit_d   = bit_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SPI_WREN_EN
    wren_d  = wren_q;
    wr_d    = wr_q;
`endif
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (start) begin
          state_d = S_SETUP;
          we_d    = we;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          sr_d    = {(we ? 8'h02 : 8'h03), addr, (we ? wdata : 8'h00)};
`ifdef SPI_WREN_EN
          wr_d   = {addr, wdata};
          wren_d = we;
          if (we) sr_d = {8'h06, 16'h0000};
`endif
        end
      end
      S_SETUP: begin
        if (div_end) begin
          state_d = S_SHIFT;
          div_d   = '0;
        end
      end
      S_SHIFT: begin
        // Each phase lasts CLK_DIV cycles; sample on the rising toggle, shift on the falling one
        if (div_end) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[6:0], miso};
          end else begin
            sr_d  = {sr_q[22:0], 1'b0};
            bit_d = bit_q + 5'd1;
            if (bit_q == bit_last) state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (div_end) begin
          state_d = S_GAP;
          div_d   = '0;
          cs_n_d  = 1'b1;
`ifdef SPI_WREN_EN
          if (!wren_q) begin
            done_d = 1'b1;
            if (!we_q) rdata_d = rx_q;
          end
`else
          done_d = 1'b1;
          if (!we_q) rdata_d = rx_q;
`endif
        end
      end
      S_GAP: begin
        if (div_end) begin
          div_d = '0;
`ifdef SPI_WREN_EN
          if (wren_q) begin
            wren_d  = 1'b0;
            state_d = S_SETUP;
            cs_n_d  = 1'b0;
            bit_d   = '0;
            sr_d    = {8'h02, wr_q};
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = S_IDLE;
          busy_d  = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPI_WREN_EN
      wren_q  <= 1'b0;
      wr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SPI_WREN_EN
      wren_q  <= wren_d;
      wr_q    <= wr_d;
`endif
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign cs_n  = cs_n_q;
  assign sck   = sck_q;
  assign mosi  = sr_q[23] & ~cs_n_q;
endmodule

// File: tb/tb_spi_ram_master.sv
// tb/tb_spi_ram_master.sv - directed scoreboard bench for spi_ram_master against a behavioural SPI RAM
`timescale 1ns/1ps
module tb_spi_ram_master;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, we = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy, done, cs_n, mosi, sck;
  logic       miso = 1'b0;

  logic       start1 = 1'b0;
  logic [7:0] rdata1;
  logic       busy1, done1, cs_n1, mosi1, sck1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_ram_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .cs_n(cs_n), .mosi(mosi), .miso(miso), .sck(sck)
  );

  spi_ram_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .we(1'b0), .addr(8'h3C), .wdata(8'h00),
    .rdata(rdata1), .busy(busy1), .done(done1), .cs_n(cs_n1), .mosi(mosi1), .miso(1'b1), .sck(sck1)
  );

  // Behavioural SPI RAM: samples mosi on sck rise, drives read data on sck fall
  logic [7:0] mem [256];
  logic [7:0] in_sr = 8'h00, out_sr = 8'h00, cmd = 8'h00, ad = 8'h00;
  int bitn = 0, sck_rises = 0, frames = 0, done_cnt = 0;
  logic [7:0] got_bytes[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] exp_rdata[$];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'h12] = 8'hA5;
  end

  always @(negedge cs_n) begin
    bitn = 0;
    frames++;
  end

  always @(posedge sck) begin
    if (!cs_n) begin
      in_sr = {in_sr[6:0], mosi};
      bitn++;
      sck_rises++;
      if (bitn % 8 == 0) got_bytes.push_back(in_sr);
      if (bitn == 8) cmd = in_sr;
      if (bitn == 16) begin
        ad = in_sr;
        out_sr = mem[ad];
      end
      if (bitn == 24 && cmd == 8'h02) mem[ad] = in_sr;
    end
  end

  always @(negedge sck) begin
    if (!cs_n && cmd == 8'h03 && bitn >= 16) begin
      miso = out_sr[7];
      out_sr = {out_sr[6:0], 1'b0};
    end
  end

  always @(posedge clk) if (done) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input bit glitch);
    int cyc, dc0, lim_done, rises, nframes;
    logic [7:0] b;
`ifdef SPI_WREN_EN
    lim_done = w ? 1 + 69 * D : 1 + 50 * D;
    rises    = w ? 32 : 24;
    nframes  = w ? 2 : 1;
    if (w) exp_bytes.push_back(8'h06);
`else
    lim_done = 1 + 50 * D;
    rises    = 24;
    nframes  = 1;
`endif
    exp_bytes.push_back(w ? 8'h02 : 8'h03);
    exp_bytes.push_back(a);
    exp_bytes.push_back(w ? d : 8'h00);
    exp_rdata.push_back(exp_rd);
    got_bytes.delete();
    sck_rises = 0;
    frames = 0;
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; we = w; addr = a; wdata = d;
    step();
    start = 1'b0;
    cyc = 1;
    check("busy_at_accept", busy, 1);
    check("cs_n_at_accept", cs_n, 0);
    while (!done && cyc < 5000) begin
      step();
      cyc++;
      if (glitch && cyc == 11) begin
        start = 1'b1; addr = 8'h77; we = 1'b1; wdata = 8'hEE;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_latency", cyc, lim_done);
    check("cs_n_at_done", cs_n, 1);
    check("rdata", rdata, exp_rdata.pop_front());
    check("sck_rises", sck_rises, rises);
    check("frames", frames, nframes);
    while (busy && cyc < 5000) begin
      step();
      cyc++;
    end
    check("busy_fall", cyc, lim_done + D);
    repeat (4 * D) step();
    check("done_count", done_cnt - dc0, 1);
    check("nbytes", got_bytes.size(), exp_bytes.size());
    while (exp_bytes.size() > 0) begin
      b = (got_bytes.size() > 0) ? got_bytes.pop_front() : 8'hxx;
      check("mosi_byte", b, exp_bytes.pop_front());
    end
  endtask

  initial begin
    int cyc, dc0, hi, lowcyc;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_sck1", sck1, 0);
    check("rst_mosi1", mosi1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    run_txn(1'b0, 8'h12, 8'h00, 8'hA5, 1'b0);
    run_txn(1'b1, 8'h5C, 8'h34, 8'hA5, 1'b0);
    check("mem_5c", mem[8'h5C], 8'h34);
    run_txn(1'b0, 8'h5C, 8'h00, 8'h34, 1'b0);
    run_txn(1'b0, 8'h12, 8'h00, 8'hA5, 1'b1);

    // Reset in the middle of a READ frame
    sck_rises = 0;
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; we = 1'b0; addr = 8'h12;
    step();
    start = 1'b0;
    cyc = 0;
    while (sck_rises < 10 && cyc < 1000) begin
      step();
      cyc++;
    end
    check("reached_10_rises", sck_rises, 10);
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", cs_n, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    check("abort_rdata", rdata, 8'h00);
    repeat (3) step();
    check("abort_no_done", done_cnt - dc0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    run_txn(1'b0, 8'h12, 8'h00, 8'hA5, 1'b0);

    // Back-to-back reads with CLK_DIV=1 and start held high
    @(negedge clk);
    start1 = 1'b1;
    cyc = 0;
    while (!done1 && cyc < 500) begin
      step();
      cyc++;
    end
    check("b2b_first_done", cyc, 51);
    for (int k = 0; k < 2; k++) begin
      check("b2b_rdata", rdata1, 8'hFF);
      check("b2b_cs_n_at_done", cs_n1, 1);
      step();
      check("b2b_done_width", done1, 0);
      hi = 1;
      while (cs_n1 && hi < 100) begin
        hi++;
        step();
      end
      check("b2b_cs_n_high", hi, 2);
      lowcyc = 0;
      while (!done1 && lowcyc < 500) begin
        step();
        lowcyc++;
      end
      check("b2b_low_to_done", lowcyc, 50);
    end
    start1 = 1'b0;
    repeat (10) step();
    check("b2b_idle_busy", busy1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
